sp_cmd_issuer: RTL
==================

Name: sp_cmd_issuer

Overview:
- Initiator-side counterpart of the SP functional unit.
- Accepts SP command descriptors on a valid/ready stream, presents them on the unit issue interface, and tracks the outstanding request ID.
- Consumes the unit writeback interface and returns results on a valid/ready response stream.
- Used in the PL for scripted/offload command sequences and as the stimulus master in unit-level benches. At most one command is outstanding, matching the SP unit's single-command busy model.

Parameters:
- ID_W, 2: width of issue/writeback ID; the ID counter wraps modulo 2^ID_W.
- DATA_W, 32: operand and result width.
- TIMEOUT_CYCLES, 1024: maximum number of cycles spent in WAIT before the command is aborted with TIMEOUT status; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command descriptor valid.
- cmd_ready  out  1  issuer can accept a command.
- cmd_fn7  in  7  SP function code; bits [4:3] select the subunit.
- cmd_rs1  in  DATA_W  operand 1.
- cmd_rs2  in  DATA_W  operand 2.
- issue_new_request  out  1  request strobe to the unit.
- issue_ready  in  1  unit not busy.
- issue_id  out  ID_W  request ID.
- issue_fn7  out  7  held copy of cmd_fn7.
- issue_rs1  out  DATA_W  held copy of cmd_rs1.
- issue_rs2  out  DATA_W  held copy of cmd_rs2.
- wb_done  in  1  unit result valid; level, held until acknowledged.
- wb_id  in  ID_W  ID of the result.
- wb_rd  in  DATA_W  result data.
- wb_ack  out  1  one-cycle acknowledge of wb_done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  result data, or 0 on error.
- rsp_fn7  out  7  fn7 of the completed command.
- rsp_status  out  2  0=OK, 1=ID_MISMATCH, 2=TIMEOUT.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 sampled at a clk edge):
  - State returns to IDLE.
  - cmd_ready=1; issue_new_request=0; wb_ack=0; rsp_valid=0; busy=0.
  - issue_id=0 and the ID counter clears to 0.
  - issue_fn7, issue_rs1 and issue_rs2 clear to 0; rsp_data=0, rsp_fn7=0, rsp_status=0.
  - The timeout counter clears.
  - Reset mid-operation abandons the outstanding command silently; no response is produced for it.
- Handshakes:
  - A cmd or rsp transfer happens on any edge where valid && ready.
  - issue_new_request is a one-cycle pulse. The request is taken on the edge where issue_new_request && issue_ready.
- States:
  - IDLE:
    - cmd_ready=1.
    - On a cmd transfer, latch fn7/rs1/rs2 into the issue_* registers, drive issue_id from the ID counter, and go to ISSUE.
  - ISSUE:
    - issue_new_request=issue_ready (combinational gate, so a strobe is never wasted).
    - When issue_ready=1, the request is taken that cycle: increment the ID counter (wrap), clear the timeout counter, go to WAIT.
    - While issue_ready=0, stay in ISSUE with operands held stable. There is no timeout in ISSUE.
  - WAIT: the timeout counter increments every cycle.
    - wb_done=1 and wb_id==issue_id: capture wb_rd and assert wb_ack for one cycle; rsp_status=OK; go to RESP.
    - wb_done=1 and wb_id!=issue_id: assert wb_ack; rsp_data=0; rsp_status=ID_MISMATCH; go to RESP.
    - wb_done=0 and the counter reaches TIMEOUT_CYCLES-1: rsp_data=0; rsp_status=TIMEOUT; go to RESP. wb_ack is not asserted.
    - Priority: if wb_done and timeout coincide, wb_done wins.
  - RESP:
    - rsp_valid=1; rsp_data, rsp_fn7 and rsp_status are held stable until the transfer.
    - On rsp_ready, go to IDLE. cmd_ready returns to 1 on the following cycle; there is no same-cycle bypass.
- Latency with issue_ready=1, zero unit latency and rsp_ready=1:
  - cmd accept at edge N;
  - issue strobe in cycle N+1;
  - earliest wb_done in cycle N+2;
  - rsp_valid in cycle N+3.
  - Throughput is one command per 4 cycles minimum.
- wb_ack is registered and asserted only in the cycle following wb_done detection. wb_done is ignored in IDLE, ISSUE and RESP states.
- After a TIMEOUT, a late wb_done for the stale ID arrives in WAIT of the next command. It is reported as ID_MISMATCH and acknowledged, which drains it.
- cmd_ready is 0 outside IDLE.
- busy = (state != IDLE).

Decomposition:
- The shared sp_unit_config package holds:
  - sp_issuer_status_t, a 2-bit enum {SP_ISSUE_OK, SP_ISSUE_ID_MISMATCH, SP_ISSUE_TIMEOUT};
  - sp_issuer_state_t {IDLE, ISSUE, WAIT, RESP};
  - the existing SP_FUNC7_* codes, reused by the bench.
- No sub-module: the FSM plus counters fit one module. The timeout counter is an inline $clog2(TIMEOUT_CYCLES)-bit register.

Test Plan:
- Basic OK:
  - Stimulus: cmd fn7=SP_FUNC7_LOAD_REG, rs1=0x10; issue_ready=1; the unit returns wb_done with wb_id=0 and wb_rd=0xDEADBEEF one cycle after the strobe.
  - Required: rsp_valid in cycle N+3 with rsp_data=0xDEADBEEF, rsp_status=0, rsp_fn7 echoed; wb_ack pulses exactly once.
- Issue backpressure:
  - Stimulus: issue_ready=0 for 5 cycles, then 1.
  - Required: a single issue_new_request pulse on the cycle issue_ready rises; operands are stable throughout.
- ID wrap: run 5 back-to-back commands with ID_W=2; required issue_id sequence is 0,1,2,3,0, and all complete with OK.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, wb_done never asserted.
  - Required: rsp_status=2 and rsp_data=0 exactly 8 cycles after the issue strobe; no wb_ack.
  - Follow-up stimulus: then wb_done with the stale id during the next command.
  - Required: ID_MISMATCH, acknowledged.
- Response backpressure and collision:
  - Stimulus: rsp_ready=0 for 10 cycles, with cmd_valid held 1.
  - Required: cmd_ready stays 0 and rsp fields stay stable. The next command is accepted the cycle after rsp_ready goes high.
  - Collision: wb_done asserted on the exact timeout cycle must yield OK.
- Reset mid-WAIT:
  - Stimulus: drive rst=0 for one cycle while in WAIT.
  - Required: rsp_valid=0, cmd_ready=1, issue_id=0 on the next cycle; no response is emitted for the abandoned command.

Source files
------------

// File: rtl/sp_unit_config.sv
// rtl/sp_unit_config.sv - Shared SP unit function codes plus issuer state and status types
package sp_unit_config;

  // fn7[4:3] selects the subunit: 0=register file, 1=ALU, 2=MAC, 3=control
  localparam logic [6:0] SP_FUNC7_LOAD_REG  = 7'b000_0000;
  localparam logic [6:0] SP_FUNC7_STORE_REG = 7'b000_0001;
  localparam logic [6:0] SP_FUNC7_ALU_ADD   = 7'b000_1000;
  localparam logic [6:0] SP_FUNC7_ALU_SUB   = 7'b000_1001;
  localparam logic [6:0] SP_FUNC7_MAC       = 7'b001_0000;
  localparam logic [6:0] SP_FUNC7_CTRL      = 7'b001_1000;

  typedef enum logic [1:0] {
    SP_ISSUE_OK          = 2'd0,
    SP_ISSUE_ID_MISMATCH = 2'd1,
    SP_ISSUE_TIMEOUT     = 2'd2
  } sp_issuer_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sp_issuer_state_t;

endpackage

// File: rtl/sp_cmd_issuer.sv
// rtl/sp_cmd_issuer.sv - Single-outstanding SP command issuer with writeback ID check and timeout
module sp_cmd_issuer
  import sp_unit_config::*;
#(
  parameter int ID_W           = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_fn7,
  input  logic [DATA_W-1:0] cmd_rs1,
  input  logic [DATA_W-1:0] cmd_rs2,
  output logic              issue_new_request,
  input  logic              issue_ready,
  output logic [ID_W-1:0]   issue_id,
  output logic [6:0]        issue_fn7,
  output logic [DATA_W-1:0] issue_rs1,
  output logic [DATA_W-1:0] issue_rs2,
  input  logic              wb_done,
  input  logic [ID_W-1:0]   wb_id,
  input  logic [DATA_W-1:0] wb_rd,
  output logic              wb_ack,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [6:0]        rsp_fn7,
  output logic [1:0]        rsp_status,
  output logic              busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  sp_issuer_state_t  state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ID_W-1:0]   issue_id_q, issue_id_d;
  logic [6:0]        issue_fn7_q, issue_fn7_d;
  logic [DATA_W-1:0] issue_rs1_q, issue_rs1_d;
  logic [DATA_W-1:0] issue_rs2_q, issue_rs2_d;
  logic              wb_ack_q, wb_ack_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [6:0]        rsp_fn7_q, rsp_fn7_d;
  sp_issuer_status_t rsp_status_q, rsp_status_d;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    tmo_d        = tmo_q;
    issue_id_d   = issue_id_q;
    issue_fn7_d  = issue_fn7_q;
    issue_rs1_d  = issue_rs1_q;
    issue_rs2_d  = issue_rs2_q;
    wb_ack_d     = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_fn7_d    = rsp_fn7_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          issue_fn7_d = cmd_fn7;
          issue_rs1_d = cmd_rs1;
          issue_rs2_d = cmd_rs2;
          issue_id_d  = id_q;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          id_d    = id_q + 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A writeback on the final timeout cycle still counts as a completion.
        if (wb_done) begin
          wb_ack_d  = 1'b1;
          rsp_fn7_d = issue_fn7_q;
          state_d   = RESP;
          if (wb_id == issue_id_q) begin
            rsp_data_d   = wb_rd;
            rsp_status_d = SP_ISSUE_OK;
          end else begin
            rsp_data_d   = '0;
            rsp_status_d = SP_ISSUE_ID_MISMATCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          rsp_fn7_d    = issue_fn7_q;
          rsp_data_d   = '0;
          rsp_status_d = SP_ISSUE_TIMEOUT;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      id_q         <= '0;
      tmo_q        <= '0;
      issue_id_q   <= '0;
      issue_fn7_q  <= '0;
      issue_rs1_q  <= '0;
      issue_rs2_q  <= '0;
      wb_ack_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_fn7_q    <= '0;
      rsp_status_q <= SP_ISSUE_OK;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      tmo_q        <= tmo_d;
      issue_id_q   <= issue_id_d;
      issue_fn7_q  <= issue_fn7_d;
      issue_rs1_q  <= issue_rs1_d;
      issue_rs2_q  <= issue_rs2_d;
      wb_ack_q     <= wb_ack_d;
      rsp_data_q   <= rsp_data_d;
      rsp_fn7_q    <= rsp_fn7_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // The strobe is gated by issue_ready so it only fires on the cycle it is taken.
  assign issue_new_request = (state_q == ISSUE) && issue_ready;
  assign cmd_ready         = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign rsp_valid         = (state_q == RESP);
  assign issue_id          = issue_id_q;
  assign issue_fn7         = issue_fn7_q;
  assign issue_rs1         = issue_rs1_q;
  assign issue_rs2         = issue_rs2_q;
  assign wb_ack            = wb_ack_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_fn7           = rsp_fn7_q;
  assign rsp_status        = rsp_status_q;

endmodule
